// File: rtl/mult_pkg.sv
// Shared widths and types for the multiplier digit path.
// Used by mult_digit_collector and its lane decoder.
package mult_pkg;

    localparam int DIGIT_W = 2;
    localparam int LANES   = 8;
    localparam int WORD_W  = 16;
    localparam int LANE_W  = 3;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [LANE_W-1:0]  lane_t;

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

endpackage

// File: rtl/mult_digit_collector_dec3to8.sv
// Lane index to one-hot lane write enables.
// Inverse of the 8:1 digit select on the sending side.
module dec3to8
    import mult_pkg::*;
(
    input  logic [LANE_W-1:0] sel_i,
    output logic [LANES-1:0]  onehot_o
);

    // Exactly one enable per lane index
    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/mult_digit_collector.sv
// Serial-to-parallel collector: eight 2-bit digits, LSB first, into a 16-bit word.
// Optional trailing even-parity beat: define MULT_DIGIT_PARITY_EN.
module mult_digit_collector
    import mult_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    input  logic               InStart,
    input  logic [DIGIT_W-1:0] InDigit,
    output logic               InReady,
    output logic [LANE_W-1:0]  Lane,
    output logic [WORD_W-1:0]  Word,
    output logic               WordValid,
    input  logic               WordReady,
    output logic               FrameErr,
    output logic               ParityErr
);

    lane_t             lane_q, lane_d, wr_lane;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d;
    logic              ferr_q, ferr_d;
    logic [LANES-1:0]  lane_we;
    logic              accept, data_beat, last_pend, done;

`ifdef MULT_DIGIT_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    logic par_ok;

    // The parity beat is the one that can stall
    assign last_pend = par_q;
    assign data_beat = accept && (InStart || !par_q);
`else
    assign last_pend = (lane_q == LAST_LANE);
    assign data_beat = accept;
`endif

    assign InReady = !(last_pend && wvalid_q && !WordReady);
    assign accept  = InValid && InReady;
    assign wr_lane = InStart ? lane_t'(0) : lane_q;

    dec3to8 u_dec (
        .sel_i    (wr_lane),
        .onehot_o (lane_we)
    );

    // Next-state: digit write, lane advance, completion and error pulses
    always_comb begin
        acc_d    = acc_q;
        lane_d   = lane_q;
        word_d   = word_q;
        wvalid_d = wvalid_q && !WordReady;
        ferr_d   = 1'b0;
        done     = 1'b0;
`ifdef MULT_DIGIT_PARITY_EN
        par_d  = par_q;
        perr_d = 1'b0;
        par_ok = 1'b0;
`endif
        if (data_beat) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_we[k]) begin
                    acc_d[k*DIGIT_W +: DIGIT_W] = InDigit;
                end
            end
            lane_d = wr_lane + lane_t'(1);
`ifdef MULT_DIGIT_PARITY_EN
            ferr_d = InStart && ((lane_q != lane_t'(0)) || par_q);
            par_d  = (wr_lane == LAST_LANE);
`else
            ferr_d = InStart && (lane_q != lane_t'(0));
            done   = (wr_lane == LAST_LANE);
`endif
        end
`ifdef MULT_DIGIT_PARITY_EN
        else if (accept) begin
            par_ok = ((^acc_q) == InDigit[0]);
            par_d  = 1'b0;
            done   = par_ok;
            perr_d = !par_ok;
        end
`endif
        if (done) begin
            word_d   = acc_d;
            wvalid_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lane_q   <= '0;
            acc_q    <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
            ferr_q   <= ferr_d;
        end
    end

`ifdef MULT_DIGIT_PARITY_EN
    // Parity-phase flag and error pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign ParityErr = perr_q;
`else
    assign ParityErr = 1'b0;
`endif

    assign Lane      = lane_q;
    assign Word      = word_q;
    assign WordValid = wvalid_q;
    assign FrameErr  = ferr_q;

endmodule

// File: tb/tb_mult_digit_collector.sv
// Self-checking bench for mult_digit_collector.
// Follows MULT_DIGIT_PARITY_EN when defined at compile time.
module tb_mult_digit_collector;

`ifdef MULT_DIGIT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, InValid, InStart;
    logic [1:0]  InDigit;
    logic        InReady;
    logic [2:0]  Lane;
    logic [15:0] Word;
    logic        WordValid, WordReady, FrameErr, ParityErr;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mult_digit_collector dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InValid   (InValid),
        .InStart   (InStart),
        .InDigit   (InDigit),
        .InReady   (InReady),
        .Lane      (Lane),
        .Word      (Word),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .FrameErr  (FrameErr),
        .ParityErr (ParityErr)
    );

    typedef struct {
        string       digs;
        logic [15:0] word;
        bit          par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] dig(input string s, input int k);
        byte c;
        c = s[k] - 8'd48;
        return c[1:0];
    endfunction

    function automatic logic [15:0] pack(input logic [1:0] d[$]);
        logic [15:0] w;
        w = '0;
        foreach (d[k]) w[2*k +: 2] = d[k];
        return w;
    endfunction

    // Entered and left on a falling edge; the beat is taken on the rising edge between
    task automatic beat(input bit s, input logic [1:0] d);
        int n;
        n = 0;
        InValid = 1'b1;
        InStart = s;
        InDigit = d;
        #1;
        while (!InReady && n < 40) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (n == 40) chk("beat_ready", InReady, 1);
        @(negedge Clk);
        InValid = 1'b0;
        InStart = 1'b0;
    endtask

    task automatic send_word(input string s, input bit p);
        for (int k = 0; k < 8; k++) begin
            beat(k == 0, dig(s, k));
            chk("sw_ferr", FrameErr, 0);
        end
        if (PAR) begin
            beat(1'b0, {1'b0, p});
            chk("sw_perr", ParityErr, 0);
        end
    endtask

    logic [1:0]  q[$];
    bit          mv, nmv, mf, mp, lastp, er;
    logic [15:0] mw, w;

    initial begin
        vecs[0] = '{"30031122", 16'hA5C3, 1'b0};
        vecs[1] = '{"33333333", 16'hFFFF, 1'b0};
        vecs[2] = '{"10000000", 16'h0001, 1'b1};
        vecs[3] = '{"01302010", 16'h1234, 1'b1};
        vecs[4] = '{"00000000", 16'h0000, 1'b0};
        vecs[5] = '{"12301230", 16'h3939, 1'b0};

        Reset     = 1'b1;
        InValid   = 1'b0;
        InStart   = 1'b0;
        InDigit   = 2'd0;
        WordReady = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_lane", Lane, 0);
        chk("rst_wv", WordValid, 0);
        chk("rst_word", Word, 0);
        chk("rst_rdy", InReady, 1);
        chk("rst_ferr", FrameErr, 0);
        chk("rst_perr", ParityErr, 0);
        Reset = 1'b0;

        // Back-to-back words from the table, downstream always ready
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) begin
                chk("tab_lane", Lane, k);
                chk("tab_rdy", InReady, 1);
                if (i == 0 && k == 7) chk("tab_wv_early", WordValid, 0);
                beat(k == 0, dig(vecs[i].digs, k));
                chk("tab_ferr", FrameErr, 0);
            end
            if (PAR) begin
                chk("tab_plane", Lane, 0);
                chk("tab_prdy", InReady, 1);
                beat(1'b0, {1'b0, vecs[i].par});
                chk("tab_perr", ParityErr, 0);
            end
            chk("tab_lane_wrap", Lane, 0);
            chk("tab_wv", WordValid, 1);
            chk("tab_word", Word, vecs[i].word);
        end
        @(negedge Clk);
        chk("drain_wv", WordValid, 0);

        // Held word: stall on the final beat, then simultaneous handshake
        WordReady = 1'b0;
        send_word("33333333", 1'b0);
        chk("hold_word1", Word, 16'hFFFF);
        for (int k = 0; k < 7; k++) beat(k == 0, dig("12301230", k));
        if (PAR) beat(1'b0, dig("12301230", 7));
        InValid = 1'b1;
        InStart = 1'b0;
        InDigit = PAR ? 2'd0 : dig("12301230", 7);
        repeat (2) begin
            #1;
            chk("hold_rdy", InReady, 0);
            @(negedge Clk);
        end
        chk("hold_wv", WordValid, 1);
        chk("hold_word", Word, 16'hFFFF);
        WordReady = 1'b1;
        #1;
        chk("hold_rdy_up", InReady, 1);
        @(negedge Clk);
        InValid = 1'b0;
        chk("hold_wv_cont", WordValid, 1);
        chk("hold_word2", Word, 16'h3939);
        @(negedge Clk);
        chk("hold_wv_done", WordValid, 0);

        // Restart after lane 3
        for (int k = 0; k < 4; k++) beat(k == 0, 2'd3);
        chk("fr_lane4", Lane, 4);
        chk("fr_pre", FrameErr, 0);
        beat(1'b1, dig("21032103", 0));
        chk("fr_pulse", FrameErr, 1);
        chk("fr_lane", Lane, 1);
        for (int k = 1; k < 8; k++) begin
            beat(1'b0, dig("21032103", k));
            chk("fr_clear", FrameErr, 0);
        end
        if (PAR) beat(1'b0, 2'd0);
        chk("fr_wv", WordValid, 1);
        chk("fr_word", Word, 16'hC6C6);
        @(negedge Clk);

        // Reset in the middle of a word
        for (int k = 0; k < 6; k++) beat(k == 0, 2'd3);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mr_lane", Lane, 0);
        chk("mr_ferr", FrameErr, 0);
        chk("mr_wv", WordValid, 0);
        chk("mr_word", Word, 0);
        send_word("01302010", 1'b1);
        chk("mr_wv2", WordValid, 1);
        chk("mr_word2", Word, 16'h1234);
        @(negedge Clk);

        if (PAR) begin
            for (int k = 0; k < 8; k++) beat(k == 0, dig("30031122", k));
            beat(1'b0, 2'd1);
            chk("par_err", ParityErr, 1);
            chk("par_wv", WordValid, 0);
            chk("par_word", Word, 16'h1234);
            @(negedge Clk);
            chk("par_err_end", ParityErr, 0);
            send_word("30031122", 1'b0);
            chk("par_ok_wv", WordValid, 1);
            chk("par_ok_word", Word, 16'hA5C3);
            @(negedge Clk);
        end

        // Randomized traffic against a digit-queue model
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        q.delete();
        mv = 1'b0;
        mw = '0;
        mf = 1'b0;
        mp = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            Reset     = ($urandom_range(0, 99) == 0);
            InValid   = ($urandom_range(0, 3) != 0);
            InStart   = ($urandom_range(0, 15) == 0);
            InDigit   = 2'($urandom_range(0, 3));
            WordReady = ($urandom_range(0, 2) != 0);
            #1;
            lastp = PAR ? (q.size() == 8) : (q.size() == 7);
            er    = !(lastp && mv && !WordReady);
            chk("r_lane", Lane, q.size() % 8);
            chk("r_rdy", InReady, er);
            chk("r_wv", WordValid, mv);
            chk("r_word", Word, mw);
            chk("r_ferr", FrameErr, mf);
            chk("r_perr", ParityErr, mp);
            nmv = mv && !WordReady;
            mf  = 1'b0;
            mp  = 1'b0;
            if (Reset) begin
                q.delete();
                nmv = 1'b0;
                mw  = '0;
            end else if (InValid && er) begin
                if (InStart) begin
                    mf = (q.size() != 0);
                    q.delete();
                    q.push_back(InDigit);
                end else if (q.size() == 8) begin
                    w = pack(q);
                    if ((^w) == InDigit[0]) begin
                        mw  = w;
                        nmv = 1'b1;
                    end else begin
                        mp = 1'b1;
                    end
                    q.delete();
                end else begin
                    q.push_back(InDigit);
                    if (!PAR && q.size() == 8) begin
                        mw  = pack(q);
                        nmv = 1'b1;
                        q.delete();
                    end
                end
            end
            mv = nmv;
            @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
